// File: rtl/gcd_binary.sv
// Iterative binary (Stein) GCD engine: shift/subtract only, one result per go.
// ready in IDLE, one-cycle done pulse, gcd holds until the next completion.
module gcd_binary #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] gcd
);
  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, REDUCE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x, y, x_nx, y_nx;
  logic [WIDTH-1:0] gcd_q, gcd_nx;
  logic [KW-1:0]    k, k_nx;
  logic [WIDTH-1:0] diff_xy, diff_yx;

  // Only consumed when both are odd and the minuend is larger.
  assign diff_xy = x - y;
  assign diff_yx = y - x;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      gcd_q <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      k     <= k_nx;
      gcd_q <= gcd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    k_nx     = k;
    gcd_nx   = gcd_q;
    case (state)
      IDLE: begin
        if (go) begin
          x_nx = a;
          y_nx = b;
          k_nx = '0;
          if (a == '0 || b == '0) begin
            gcd_nx   = a | b;
            state_nx = DONE;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Strip the common power of two, remembered in k.
        if (!x[0] && !y[0]) begin
          x_nx = x >> 1;
          y_nx = y >> 1;
          k_nx = k + KW'(1);
        end else begin
          state_nx = REDUCE;
        end
      end
      REDUCE: begin
        if (!x[0]) begin
          x_nx = x >> 1;
        end else if (!y[0]) begin
          y_nx = y >> 1;
        end else if (x == y) begin
          gcd_nx   = x << k;
          state_nx = DONE;
        end else if (x > y) begin
          x_nx = diff_xy >> 1;
        end else begin
          y_nx = diff_yx >> 1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign gcd   = gcd_q;

endmodule

// File: tb/tb_gcd_binary.sv
// Bench for gcd_binary at WIDTH=32 and WIDTH=8: Euclid/latency reference model
// checked every cycle, plus directed literal cases.
module tb_gcd_binary;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic        rst32, go32, rdy32, done32;
  logic [31:0] a32, b32, gcd32;
  logic        rst8, go8, rdy8, done8;
  logic [7:0]  a8, b8, gcd8;

  gcd_binary #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .go(go32), .a(a32), .b(b32),
    .ready(rdy32), .done(done32), .gcd(gcd32)
  );
  gcd_binary #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .go(go8), .a(a8), .b(b8),
    .ready(rdy8), .done(done8), .gcd(gcd8)
  );

  typedef struct {
    int     remain;
    bit     in_done;
    longint exp_gcd;
    longint pend;
    int     age;
    int     ndone;
    longint last_gcd;
    int     last_l;
  } mst_t;

  mst_t m32, m8;

  function automatic void chk(bit ok, string nm, longint got, longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endfunction

  function automatic longint euclid(longint p, longint q);
    longint t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Cycles from acceptance to done: 1 for a zero operand, else
  // 1 + (common twos + exit) + reduce steps including the final equality step.
  function automatic int lat_model(longint p, longint q);
    int tz = 0;
    int steps = 0;
    longint x = p;
    longint y = q;
    if (p == 0 || q == 0) return 1;
    while (x % 2 == 0 && y % 2 == 0) begin
      x = x / 2;
      y = y / 2;
      tz++;
    end
    while (x % 2 == 0 || y % 2 == 0 || x != y) begin
      steps++;
      if (x % 2 == 0)      x = x / 2;
      else if (y % 2 == 0) y = y / 2;
      else if (x > y)      x = (x - y) / 2;
      else                 y = (y - x) / 2;
    end
    return 3 + tz + steps;
  endfunction

  task automatic mon(input int w, input logic r, input logic g, input longint av,
                     input longint bv, input logic rd, input logic dn, input longint gv,
                     inout mst_t s, input string tag);
    bit er;
    int l;
    if (!mon_en) return;
    er = (s.remain == 0) && !s.in_done;
    chk(rd === er, {tag, " ready"}, longint'(rd), longint'(er));
    chk(dn === s.in_done, {tag, " done"}, longint'(dn), longint'(s.in_done));
    chk(gv == s.exp_gcd, {tag, " gcd"}, gv, s.exp_gcd);
    if (dn === 1'b1) begin
      s.ndone++;
      s.last_gcd = gv;
      s.last_l   = s.age;
    end
    s.age++;
    if (r) begin
      s.remain  = 0;
      s.in_done = 1'b0;
      s.exp_gcd = 0;
    end else if (s.in_done) begin
      s.in_done = 1'b0;
    end else if (s.remain > 0) begin
      s.remain--;
      if (s.remain == 0) begin
        s.in_done = 1'b1;
        s.exp_gcd = s.pend;
      end
    end else if (g) begin
      s.pend = euclid(av, bv);
      l = lat_model(av, bv);
      s.age = 1;
      chk(l <= 3 * w + 3, {tag, " latency bound"}, l, 3 * w + 3);
      if (l == 1) begin
        s.in_done = 1'b1;
        s.exp_gcd = s.pend;
      end else begin
        s.remain = l - 1;
      end
    end
  endtask

  always @(negedge clk) mon(32, rst32, go32, a32, b32, rdy32, done32, gcd32, m32, "w32");
  always @(negedge clk) mon(8, rst8, go8, a8, b8, rdy8, done8, gcd8, m8, "w8");

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle32(input string nm);
    int t = 0;
    while (rdy32 !== 1'b1 && t < 500) begin
      step();
      t++;
    end
    chk(t < 500, {nm, " idle timeout"}, t, 500);
  endtask

  task automatic req32(input logic [31:0] av, input logic [31:0] bv,
                       input longint eg, input int el, input string nm);
    int n0;
    int t = 0;
    wait_idle32(nm);
    n0 = m32.ndone;
    a32 = av;
    b32 = bv;
    go32 = 1'b1;
    step();
    go32 = 1'b0;
    a32 = $urandom;
    b32 = $urandom;
    while (m32.ndone == n0 && t < 500) begin
      step();
      t++;
    end
    chk(m32.ndone == n0 + 1, {nm, " done count"}, m32.ndone - n0, 1);
    chk(m32.last_gcd == eg, {nm, " result"}, m32.last_gcd, eg);
    chk(m32.last_l == el, {nm, " latency"}, m32.last_l, el);
  endtask

  function automatic longint pick(int w);
    longint mx = (longint'(1) << w) - 1;
    case ($urandom_range(15))
      0:       return mx;
      1:       return 0;
      2, 3:    return longint'($urandom_range(20)) + 1;
      4:       return longint'(1) << $urandom_range(w - 1);
      5:       return mx - longint'($urandom_range(3));
      6:       return (longint'($urandom) & mx) | 1;
      default: return longint'($urandom) & mx;
    endcase
  endfunction

  task automatic rand32(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      go32 = ($urandom_range(7) != 0);
      a32 = 32'(pick(32));
      b32 = 32'(pick(32));
      step();
    end
    go32 = 1'b0;
  endtask

  task automatic rand8(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      go8 = ($urandom_range(7) != 0);
      a8 = 8'(pick(8));
      b8 = 8'(pick(8));
      step();
    end
    go8 = 1'b0;
  endtask

  initial begin
    int n0;
    rst32 = 1'b1; rst8 = 1'b1; go32 = 1'b0; go8 = 1'b0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    rst32 = 1'b0;
    rst8 = 1'b0;
    chk(gcd32 == 0, "reset gcd32", gcd32, 0);
    chk(rdy32 == 1'b1, "reset ready32", rdy32, 1);
    chk(done8 == 1'b0, "reset done8", done8, 0);

    req32(100, 36, 4, 12, "100_36");
    req32(12, 12, 12, 5, "12_12");
    req32(0, 7, 7, 1, "0_7");
    req32(9, 0, 9, 1, "9_0");
    req32(0, 0, 0, 1, "0_0");
    req32(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, lat_model(64'hFFFF_FFFF, 64'hFFFF_FFFE), "max");

    // go held high with a stepping; every acceptance is scored by the monitor
    wait_idle32("held");
    n0 = m32.ndone;
    go32 = 1'b1;
    b32 = 36;
    for (int s = 0; s < 3; s++) begin
      a32 = 32'(100 + 37 * s);
      repeat (600) step();
    end
    go32 = 1'b0;
    chk(m32.ndone - n0 > 50, "held result count", m32.ndone - n0, 51);

    // mid-run reset aborts without a done pulse
    wait_idle32("midrun");
    n0 = m32.ndone;
    a32 = 32'h8000_0000;
    b32 = 3;
    go32 = 1'b1;
    step();
    go32 = 1'b0;
    repeat (4) step();
    rst32 = 1'b1;
    step();
    rst32 = 1'b0;
    chk(rdy32 == 1'b1, "midrun ready", rdy32, 1);
    chk(gcd32 == 0, "midrun gcd", gcd32, 0);
    repeat (120) step();
    chk(m32.ndone == n0, "midrun no done", m32.ndone - n0, 0);
    req32(12, 18, 6, lat_model(12, 18), "post_reset");

    fork
      rand32(55000);
      rand8(55000);
    join
    repeat (120) step();
    chk(m32.ndone > 300, "w32 random count", m32.ndone, 301);
    chk(m8.ndone > 1000, "w8 random count", m8.ndone, 1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
